// File: rtl/cdc_evt_pkg.sv
// Shared types and constants for the CDC event scheduler.
// Optional feature macro: CDC_EVT_DROP_CNT_EN (per-requester drop counters).
package cdc_evt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam int DEF_GUARD_CYCLES = 8;
    localparam int DEF_DROP_CNT_W   = 8;

    // Largest value a saturating counter of the given width may hold
    function automatic longint unsigned satLimit(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping around. The pointer itself is owned by the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CODE_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [CODE_W-1:0]  i_ptr,
    output logic [CODE_W-1:0]  o_grant,
    output logic               o_valid
);

    logic [NUM_REQ-1:0] w_rot;

    // Rotate the request vector so the pointer position lands on bit 0
    assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

    // Scan the rotated vector and translate the first hit back to an index
    always_comb begin
        int s;
        o_valid = 1'b0;
        o_grant = '0;
        s       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_valid && w_rot[k]) begin
                o_valid = 1'b1;
                s       = int'(i_ptr) + k;
                if (s >= NUM_REQ) begin
                    s = s - NUM_REQ;
                end
                o_grant = CODE_W'(s);
            end
        end
    end

endmodule

// File: rtl/cdc_event_scheduler.sv
// Fast-domain scheduler sharing one pulse-synchronizer channel among several
// requesters. Requests are latched, arbitrated round-robin, issued as a
// one-cycle pulse with a held code, then followed by a guard window.
// Optional feature macro: CDC_EVT_DROP_CNT_EN adds saturating drop counters.
module cdc_event_scheduler
    import cdc_evt_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CODE_W       = $clog2(NUM_REQ),
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
`ifdef CDC_EVT_DROP_CNT_EN
    ,
    parameter int DROP_CNT_W   = DEF_DROP_CNT_W
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic                      drop_clr,
    output logic                      evt_pulse,
    output logic [CODE_W-1:0]         evt_code,
    output logic                      busy,
    output logic [NUM_REQ-1:0]        pending,
    output logic [NUM_REQ-1:0]        drop_flag
`ifdef CDC_EVT_DROP_CNT_EN
    ,
    output logic [NUM_REQ*DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam int GCNT_W = $clog2(GUARD_CYCLES + 1);

    state_t              r_state;
    logic [CODE_W-1:0]   r_ptr;
    logic [CODE_W-1:0]   r_code;
    logic                r_evtPulse;
    logic                r_busy;
    logic [GCNT_W-1:0]   r_guardCnt;
    logic [NUM_REQ-1:0]  r_pending;
    logic [NUM_REQ-1:0]  r_dropFlag;

    logic [NUM_REQ-1:0]  w_issueMask;
    logic [NUM_REQ-1:0]  w_pendingNext;
    logic [NUM_REQ-1:0]  w_drop;
    logic [NUM_REQ-1:0]  w_arbReq;
    logic [CODE_W-1:0]   w_grant;
    logic                w_valid;
    logic [CODE_W-1:0]   w_ptrNext;

    // Pending bookkeeping: the issued requester is retired after its ISSUE
    // cycle, while a same-cycle re-request keeps it latched without a drop
    always_comb begin
        w_issueMask   = (r_state == ISSUE) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_code) : '0;
        w_pendingNext = (r_pending & ~w_issueMask) | req;
        w_drop        = req & r_pending & ~w_issueMask;
        w_arbReq      = (r_state == GUARD) ? w_pendingNext : r_pending;
        w_ptrNext     = (w_grant == CODE_W'(NUM_REQ - 1)) ? '0 : w_grant + CODE_W'(1);
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .CODE_W  (CODE_W)
    ) u_arb (
        .i_req   (w_arbReq),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    // Scheduler FSM with registered pulse, code and busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_code     <= '0;
            r_evtPulse <= 1'b0;
            r_busy     <= 1'b0;
            r_guardCnt <= '0;
            r_pending  <= '0;
        end else begin
            r_evtPulse <= 1'b0;
            r_pending  <= w_pendingNext;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state    <= ISSUE;
                        r_evtPulse <= 1'b1;
                        r_code     <= w_grant;
                        r_ptr      <= w_ptrNext;
                        r_busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state    <= GUARD;
                    r_guardCnt <= GCNT_W'(GUARD_CYCLES);
                end
                GUARD: begin
                    r_guardCnt <= r_guardCnt - GCNT_W'(1);
                    if (r_guardCnt == GCNT_W'(1)) begin
                        if (w_valid) begin
                            r_state    <= ISSUE;
                            r_evtPulse <= 1'b1;
                            r_code     <= w_grant;
                            r_ptr      <= w_ptrNext;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky drop flags; a clear wins over a simultaneous new drop
    always_ff @(posedge clk) begin
        if (rst || drop_clr) begin
            r_dropFlag <= '0;
        end else begin
            r_dropFlag <= r_dropFlag | w_drop;
        end
    end

    assign evt_pulse = r_evtPulse;
    assign evt_code  = r_code;
    assign busy      = r_busy;
    assign pending   = r_pending;
    assign drop_flag = r_dropFlag;

`ifdef CDC_EVT_DROP_CNT_EN
    localparam logic [DROP_CNT_W-1:0] SAT_MAX = DROP_CNT_W'(satLimit(DROP_CNT_W));

    logic [DROP_CNT_W-1:0] r_dropCnt [NUM_REQ];

    // Per-requester saturating drop counters; a clear wins over an increment
    always_ff @(posedge clk) begin
        if (rst || drop_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_dropCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_drop[i] && (r_dropCnt[i] != SAT_MAX)) begin
                    r_dropCnt[i] <= r_dropCnt[i] + DROP_CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_dropCnt
        assign drop_cnt[g*DROP_CNT_W +: DROP_CNT_W] = r_dropCnt[g];
    end
`endif

endmodule

// File: tb/tb_cdc_event_scheduler.sv
// Directed self-checking bench for cdc_event_scheduler (NUM_REQ=4,
// GUARD_CYCLES=8). Inputs change 1 time unit after each rising edge and
// outputs are sampled at that same point, away from the edge.
module tb_cdc_event_scheduler;

    localparam int NUM_REQ = 4;
    localparam int GUARD   = 8;
    localparam int CODE_W  = 2;
    localparam int DCW     = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic                 drop_clr;
    logic                 evt_pulse;
    logic [CODE_W-1:0]    evt_code;
    logic                 busy;
    logic [NUM_REQ-1:0]   pending;
    logic [NUM_REQ-1:0]   drop_flag;
`ifdef CDC_EVT_DROP_CNT_EN
    logic [NUM_REQ*DCW-1:0] drop_cnt;
`endif

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    cdc_event_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .CODE_W       (CODE_W),
        .GUARD_CYCLES (GUARD)
`ifdef CDC_EVT_DROP_CNT_EN
        ,
        .DROP_CNT_W   (DCW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .drop_clr  (drop_clr),
        .evt_pulse (evt_pulse),
        .evt_code  (evt_code),
        .busy      (busy),
        .pending   (pending),
        .drop_flag (drop_flag)
`ifdef CDC_EVT_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle request pulse; returns one cycle later with req low
    task automatic applyStimulus(input logic [NUM_REQ-1:0] v);
        req = v;
        tick();
        req = '0;
    endtask

    // Advance until evt_pulse is seen, bounded; reports cycles elapsed
    task automatic waitPulse(input string tag, input int limit, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!evt_pulse && cycles < limit);
        if (!evt_pulse) begin
            checkOutput({tag, "_timeout"}, 32'(evt_pulse), 32'd1);
        end
    endtask

    // Advance until the scheduler is idle, bounded
    task automatic waitIdle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        if (busy) begin
            checkOutput({tag, "_idle_timeout"}, 32'(busy), 32'd0);
        end
    endtask

    // Directed test sequence
    initial begin
        int gap;
        int pulses;

        rst      = 1'b1;
        req      = '0;
        drop_clr = 1'b0;
        repeat (3) tick();
        checkOutput("rst_pulse",   32'(evt_pulse), 32'd0);
        checkOutput("rst_code",    32'(evt_code),  32'd0);
        checkOutput("rst_busy",    32'(busy),      32'd0);
        checkOutput("rst_pending", 32'(pending),   32'd0);
        checkOutput("rst_drop",    32'(drop_flag), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        $display("[TB] all four requesters at once");
        applyStimulus(4'b1111);
        checkOutput("all_pending", 32'(pending), 32'hF);
        tick();
        checkOutput("all_pulse0", 32'(evt_pulse), 32'd1);
        checkOutput("all_code0",  32'(evt_code),  32'd0);
        for (int k = 1; k < NUM_REQ; k++) begin
            waitPulse("all_wait", 20, gap);
            checkOutput($sformatf("all_gap%0d", k),  32'(gap),      32'(GUARD + 1));
            checkOutput($sformatf("all_code%0d", k), 32'(evt_code), 32'(k));
        end
        waitIdle("all", 20);
        checkOutput("all_pending_done", 32'(pending), 32'd0);

        $display("[TB] single request");
        applyStimulus(4'b0100);
        checkOutput("single_pending",  32'(pending),   32'h4);
        checkOutput("single_nopulse",  32'(evt_pulse), 32'd0);
        checkOutput("single_busy_pre", 32'(busy),      32'd0);
        tick();
        checkOutput("single_pulse", 32'(evt_pulse), 32'd1);
        checkOutput("single_code",  32'(evt_code),  32'd2);
        checkOutput("single_busy",  32'(busy),      32'd1);
        tick();
        checkOutput("single_pulse_off", 32'(evt_pulse), 32'd0);
        checkOutput("single_cleared",   32'(pending),   32'd0);
        repeat (GUARD - 1) tick();
        checkOutput("single_busy_last", 32'(busy), 32'd1);
        tick();
        checkOutput("single_idle", 32'(busy),     32'd0);
        checkOutput("single_hold", 32'(evt_code), 32'd2);

        $display("[TB] round-robin fairness");
        applyStimulus(4'b1000);
        waitPulse("rr_pre", 5, gap);
        checkOutput("rr_pre_code", 32'(evt_code), 32'd3);
        waitIdle("rr_pre", 20);
        applyStimulus(4'b1001);
        tick();
        checkOutput("rr_first_pulse", 32'(evt_pulse), 32'd1);
        checkOutput("rr_first_code",  32'(evt_code),  32'd0);
        waitPulse("rr_second", 20, gap);
        checkOutput("rr_second_gap",  32'(gap),      32'(GUARD + 1));
        checkOutput("rr_second_code", 32'(evt_code), 32'd3);
        waitIdle("rr", 20);

        $display("[TB] drop while pending");
        applyStimulus(4'b0001);
        tick();
        checkOutput("drop_issue0", 32'(evt_pulse), 32'd1);
        tick();
        req = 4'b0010;
        tick();
        checkOutput("drop_flag_pre", 32'(drop_flag), 32'd0);
        checkOutput("drop_pending",  32'(pending),   32'h2);
        tick();
        req = '0;
        checkOutput("drop_flag_set", 32'(drop_flag), 32'h2);
`ifdef CDC_EVT_DROP_CNT_EN
        checkOutput("drop_cnt1", 32'(drop_cnt[1*DCW +: DCW]), 32'd1);
        checkOutput("drop_cnt0", 32'(drop_cnt[0*DCW +: DCW]), 32'd0);
`endif
        waitPulse("drop_issue", 20, gap);
        checkOutput("drop_issue_gap",  32'(gap),      32'd6);
        checkOutput("drop_issue_code", 32'(evt_code), 32'd1);
        waitIdle("drop", 20);
        checkOutput("drop_merged", 32'(pending), 32'd0);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        checkOutput("drop_clr_flag", 32'(drop_flag), 32'd0);
`ifdef CDC_EVT_DROP_CNT_EN
        checkOutput("drop_clr_cnt", 32'(drop_cnt[1*DCW +: DCW]), 32'd0);
`endif

        $display("[TB] same-cycle re-request");
        applyStimulus(4'b0001);
        tick();
        checkOutput("rereq_pulse", 32'(evt_pulse), 32'd1);
        checkOutput("rereq_code",  32'(evt_code),  32'd0);
        req = 4'b0001;
        tick();
        req = '0;
        checkOutput("rereq_pending", 32'(pending),   32'h1);
        checkOutput("rereq_nodrop",  32'(drop_flag), 32'd0);
        waitPulse("rereq_second", 20, gap);
        checkOutput("rereq_gap",  32'(gap + 1),  32'(GUARD + 1));
        checkOutput("rereq_code2", 32'(evt_code), 32'd0);
        waitIdle("rereq", 20);
        checkOutput("rereq_nodrop_end", 32'(drop_flag), 32'd0);

        $display("[TB] reset during guard");
        applyStimulus(4'b1000);
        tick();
        checkOutput("mrst_issue", 32'(evt_pulse), 32'd1);
        tick();
        req = 4'b0110;
        tick();
        req = '0;
        checkOutput("mrst_pending", 32'(pending), 32'h6);
        checkOutput("mrst_busy",    32'(busy),    32'd1);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checkOutput("mrst_pulse",   32'(evt_pulse), 32'd0);
        checkOutput("mrst_code",    32'(evt_code),  32'd0);
        checkOutput("mrst_busy0",   32'(busy),      32'd0);
        checkOutput("mrst_pend0",   32'(pending),   32'd0);
        checkOutput("mrst_drop0",   32'(drop_flag), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (evt_pulse || busy) begin
                pulses++;
            end
        end
        checkOutput("mrst_quiet", 32'(pulses), 32'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Global safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
